// File: rtl/fetch_pkg.sv
// Shared constants and the entry type carried through the fetch queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched instructions; flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited memory requests and
// queues returned instructions for decode, squashing stale ones on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] RESET_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;
  logic            credit;
  logic            req_fire;
  logic            unused_bits;

  // Requests in flight plus queued entries may never exceed the queue size,
  // so a response always has a slot waiting for it.
  assign credit           = ({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(DEPTH);
  assign imem_req_valid   = reset && credit && !redirect_valid;
  assign imem_req_addr    = {pc[XLEN-1:2], 2'b00};
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits      = ^{redirect_pc[1:0], pc[1:0]};

  assign q_push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign q_pop       = instr_valid && instr_ready;
  assign q_push_data = '{instr: imem_rsp_data, pc: fetch_pc};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_data(q_push_data),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign instr_valid   = !q_empty;
  assign instr         = q_empty ? '0 : q_head.instr;
  assign instr_pc      = q_empty ? '0 : q_head.pc;
  assign instr_pcplus4 = q_empty ? '0 : q_head.pc + XLEN'(4);

  // fetch_pc names the next response that will be kept; it only moves on
  // pushes, so dropped responses never disturb the PC tagging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_ALIGNED;
      fetch_pc    <= RESET_ALIGNED;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= redirect_aligned;
        fetch_pc <= redirect_aligned;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (q_push) fetch_pc <= fetch_pc + XLEN'(4);
        else if (imem_rsp_valid) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset) !(q_push && q_full && !q_pop)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural memory, a scoreboard of
// expected decode-side entries, and a monitor that compares each handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int mem_lat      = 1;

  logic        smp_req_valid;
  logic [31:0] smp_req_addr;
  logic        smp_instr_valid;
  logic [31:0] smp_instr_pc;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pcplus4 (instr_pcplus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_acc(input string name, input int idx, input logic [31:0] req);
    logic [31:0] act;
    act = (idx < acc_log.size()) ? acc_log[idx] : 32'hxxxx_xxxx;
    check_output(name, act, req);
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
    exp_q.push_back('{instr: i, pc: p, pcp4: p4});
  endtask

  // One clock cycle, entered and left at a falling edge: drive the memory
  // response, sample the DUT, record any accepted request, and end the
  // redirect pulse.
  task automatic apply_stimulus();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    smp_req_valid   = imem_req_valid;
    smp_req_addr    = imem_req_addr;
    smp_instr_valid = instr_valid;
    smp_instr_pc    = instr_pc;
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      acc_log.push_back(imem_req_addr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    acc_log.delete();
  endtask

  // Monitor: every decode handshake pops the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_instr: got instr %h pc %h, expected nothing", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          check_output("instr", instr, e.instr);
          check_output("instr_pc", instr_pc, e.pc);
          check_output("instr_pcplus4", instr_pcplus4, e.pcp4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    #1;
    check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_output("rst_instr", instr, 32'h0);
    check_output("rst_instr_pc", instr_pc, 32'h0);
    check_output("rst_instr_pcplus4", instr_pcplus4, 32'h0);
    check_output("rst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    acc_log.delete();

    // Streaming with a 1-cycle memory.
    $display("[TB] test: stream");
    expect_instr(32'h0000_0013, 32'h0, 32'h4);
    expect_instr(32'h0000_0413, 32'h4, 32'h8);
    expect_instr(32'h0000_0813, 32'h8, 32'hC);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    apply_stimulus();
    check_output("s_first_req_valid", 32'(smp_req_valid), 32'd1);
    check_output("s_c0_instr_valid", 32'(smp_instr_valid), 32'd0);
    apply_stimulus();
    check_output("s_c1_instr_valid", 32'(smp_instr_valid), 32'd0);
    apply_stimulus();
    check_output("s_c2_instr_valid", 32'(smp_instr_valid), 32'd1);
    check_output("s_c2_credit_block", 32'(smp_req_valid), 32'd0);
    apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (4) apply_stimulus();
    check_output("s_acc_count", 32'(acc_log.size()), 32'd3);
    check_acc("s_acc0", 0, 32'h0);
    check_acc("s_acc1", 1, 32'h4);
    check_acc("s_acc2", 2, 32'h8);

    // Decode stalled: credit limits fetch to two entries.
    $display("[TB] test: backpressure");
    do_reset();
    expect_instr(32'h0000_0013, 32'h0, 32'h4);
    expect_instr(32'h0000_0413, 32'h4, 32'h8);
    expect_instr(32'h0000_0813, 32'h8, 32'hC);
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    repeat (6) apply_stimulus();
    check_output("bp_req_valid", 32'(smp_req_valid), 32'd0);
    check_output("bp_instr_valid", 32'(smp_instr_valid), 32'd1);
    check_output("bp_head_pc", smp_instr_pc, 32'h0);
    check_output("bp_acc_count", 32'(acc_log.size()), 32'd2);
    instr_ready = 1'b1;
    repeat (2) apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (3) apply_stimulus();
    check_output("bp_acc_total", 32'(acc_log.size()), 32'd3);
    check_acc("bp_resume_addr", 2, 32'h8);

    // Redirect with two fetches in flight.
    $display("[TB] test: redirect in flight");
    do_reset();
    expect_instr(32'h0001_0013, 32'h100, 32'h104);
    mem_lat        = 3;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    apply_stimulus();
    check_output("rd_no_req_in_redirect", 32'(smp_req_valid), 32'd0);
    repeat (2) apply_stimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    apply_stimulus();
    check_output("rd_no_req_second", 32'(smp_req_valid), 32'd0);
    repeat (2) apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (6) apply_stimulus();
    check_acc("rd_acc0", 0, 32'h10);
    check_acc("rd_acc1", 1, 32'h14);
    check_acc("rd_acc2", 2, 32'h100);
    check_output("rd_acc_count", 32'(acc_log.size()), 32'd3);

    // Redirect coincident with a response and a decode handshake.
    $display("[TB] test: redirect coincident");
    do_reset();
    expect_instr(32'h0000_0013, 32'h0, 32'h4);
    expect_instr(32'h0002_0013, 32'h200, 32'h204);
    mem_lat        = 1;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    repeat (2) apply_stimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    apply_stimulus();
    check_output("rc_head_valid", 32'(smp_instr_valid), 32'd1);
    check_output("rc_head_pc", smp_instr_pc, 32'h0);
    apply_stimulus();
    check_output("rc_flushed_valid", 32'(smp_instr_valid), 32'd0);
    check_output("rc_flushed_pc", smp_instr_pc, 32'h0);
    imem_req_ready = 1'b0;
    repeat (3) apply_stimulus();
    check_acc("rc_acc2", 2, 32'h200);

    // Misaligned redirect target.
    $display("[TB] test: misaligned redirect");
    acc_log.delete();
    expect_instr(32'h0001_0013, 32'h100, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    apply_stimulus();
    check_output("ma_no_req", 32'(smp_req_valid), 32'd0);
    apply_stimulus();
    check_output("ma_req_valid", 32'(smp_req_valid), 32'd1);
    check_output("ma_req_addr", smp_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (3) apply_stimulus();
    check_acc("ma_acc0", 0, 32'h100);

    // Asynchronous reset mid-stream.
    $display("[TB] test: async reset");
    acc_log.delete();
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (2) apply_stimulus();
    check_output("ar_pre_instr_valid", 32'(smp_instr_valid), 32'd1);
    check_output("ar_pre_req_valid", 32'(smp_req_valid), 32'd1);
    check_output("ar_pre_instr_pc", smp_instr_pc, 32'h104);
    #3;
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_q.delete();
    #1;
    check_output("ar_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("ar_instr_valid", 32'(instr_valid), 32'd0);
    check_output("ar_instr_pc", instr_pc, 32'h0);
    check_output("ar_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    acc_log.delete();
    expect_instr(32'h0000_0013, 32'h0, 32'h4);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    apply_stimulus();
    imem_req_ready = 1'b0;
    repeat (3) apply_stimulus();
    check_acc("ar_first_addr", 0, 32'h0);

    repeat (2) apply_stimulus();
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
